// File: rtl/imem_boot_loader.sv
// Boot-time instruction-memory loader: streams words into imem, holds the CPU in reset, then releases it.
// Optional trailer checksum check is enabled by defining IMEM_BOOT_CHECKSUM_EN.
module imem_boot_loader #(
   parameter int unsigned ADDR_W      = 9,
   parameter int unsigned HOLD_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_start,
   input  logic [ADDR_W:0]   load_len,
   input  logic              word_valid,
   input  logic [31:0]       word_data,
   output logic              word_ready,
   input  logic [ADDR_W-1:0] cpu_pc,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_rst_n,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int unsigned LEN_W  = ADDR_W + 1;
   localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [LEN_W-1:0]  DEPTH     = LEN_W'(1) << ADDR_W;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_CHK   = 3'd2,
      S_HOLD  = 3'd3,
      S_RUN   = 3'd4,
      S_ERROR = 3'd5
   } state_t;

   state_t              state_q;
   state_t              state_d;
   logic [LEN_W-1:0]    len_q;
   logic [LEN_W-1:0]    count_q;
   logic [HOLD_W-1:0]   hold_q;
   logic [ADDR_W-1:0]   wr_addr_q;
   logic [LEN_W-1:0]    len_clamp;
   logic                load_hs;
   logic                last_word;
   logic                start_ok;

`ifdef IMEM_BOOT_CHECKSUM_EN
   logic [31:0]         sum_q;
`endif

   // Handshake happens only in LOAD, where ready is decoded high
   assign load_hs   = (state_q == S_LOAD) && word_valid;
   assign last_word = (count_q == (len_q - 1'b1));
   assign start_ok  = load_start &&
                      ((state_q == S_IDLE) || (state_q == S_RUN) || (state_q == S_ERROR));
   assign len_clamp = (load_len > DEPTH) ? DEPTH : load_len;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_RUN, S_ERROR: begin
            if (load_start) begin
               if (load_len != '0) state_d = S_LOAD;
`ifdef IMEM_BOOT_CHECKSUM_EN
               else                state_d = S_CHK;
`else
               else                state_d = S_HOLD;
`endif
            end
         end
         S_LOAD: begin
            if (word_valid && last_word) begin
`ifdef IMEM_BOOT_CHECKSUM_EN
               state_d = S_CHK;
`else
               state_d = S_HOLD;
`endif
            end
         end
`ifdef IMEM_BOOT_CHECKSUM_EN
         S_CHK: begin
            if (word_valid) state_d = (word_data == sum_q) ? S_HOLD : S_ERROR;
         end
`endif
         S_HOLD: begin
            if (hold_q == HOLD_LAST) state_d = S_RUN;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Decoded outputs; the address port belongs to the CPU only in RUN
   always_comb begin
      word_ready = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      err        = 1'b0;
      imem_addr  = wr_addr_q;
      case (state_q)
         S_LOAD: begin
            word_ready = 1'b1;
            busy       = 1'b1;
         end
`ifdef IMEM_BOOT_CHECKSUM_EN
         S_CHK:   word_ready = 1'b1;
         S_ERROR: err        = 1'b1;
`endif
         S_HOLD:  busy       = 1'b1;
         S_RUN: begin
            done      = 1'b1;
            imem_addr = cpu_pc;
         end
         default: ;
      endcase
   end

   // Datapath: write pipeline, counters and CPU reset release
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         len_q      <= '0;
         count_q    <= '0;
         hold_q     <= '0;
         wr_addr_q  <= '0;
         imem_we    <= 1'b0;
         imem_wdata <= '0;
         cpu_rst_n  <= 1'b0;
`ifdef IMEM_BOOT_CHECKSUM_EN
         sum_q      <= '0;
`endif
      end else begin
         imem_we   <= load_hs;
         cpu_rst_n <= (state_d == S_RUN);
         hold_q    <= (state_q == S_HOLD) ? hold_q + 1'b1 : '0;
         if (start_ok) begin
            len_q   <= len_clamp;
            count_q <= '0;
`ifdef IMEM_BOOT_CHECKSUM_EN
            sum_q   <= '0;
`endif
         end
         if (load_hs) begin
            wr_addr_q  <= count_q[ADDR_W-1:0];
            imem_wdata <= word_data;
            count_q    <= count_q + 1'b1;
`ifdef IMEM_BOOT_CHECKSUM_EN
            sum_q      <= sum_q + word_data;
`endif
         end
      end
   end

endmodule
